// File: rtl/fir_shift_add_stream.sv
// Streaming FIR filter: one tap per cycle, each product built by shift-and-add
// over the coefficient bits. Accept -> MAC (TAPS cycles) -> DONE -> result pulse.
`timescale 1ns/1ps
module fir_shift_add_stream #(
  parameter int DATA_W = 4,
  parameter int COEF_W = 4,
  parameter int TAPS   = 10,
  parameter int OUT_W  = 16,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic                     busy
);

  localparam int AW    = $clog2(TAPS);
  localparam int AW1   = AW + 1;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   x_r [TAPS];
  logic [COEF_W-1:0]   h_r [TAPS];
  logic [ACC_W-1:0]    acc_r;
  logic [AW-1:0]       idx_r;
  logic [OUT_W-1:0]    out_data_r;
  logic                out_valid_r;
  logic [ACC_W-1:0]    prod_s;
  logic [ACC_W-1:0]    acc_next_s;
  logic                addr_ok_s;

  function automatic logic [ACC_W-1:0] shift_add(input logic [COEF_W-1:0] h,
                                                 input logic [DATA_W-1:0] x);
    logic [ACC_W-1:0] p;
    p = '0;
    for (int b = 0; b < COEF_W; b++) begin
      if (h[b]) p = p + (ACC_W'(x) << b);
      else      p = p;
    end
    return p;
  endfunction

  // Widened copy lets the overflow test work whether OUT_W is above or below ACC_W.
  function automatic logic [OUT_W-1:0] clamp(input logic [ACC_W-1:0] a);
    logic [ACC_W+OUT_W-1:0] e;
    e = {{OUT_W{1'b0}}, a};
    if ((SAT != 0) && ((e >> OUT_W) != '0)) return '1;
    else                                    return e[OUT_W-1:0];
  endfunction

  // Current tap product and next accumulator value.
  always_comb begin
    prod_s     = shift_add(h_r[idx_r], x_r[idx_r]);
    acc_next_s = acc_r + prod_s;
    addr_ok_s  = ({1'b0, coef_addr} < AW1'(TAPS));
  end

  // Control FSM plus delay line, coefficient bank and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      idx_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
        h_r[k] <= COEF_W'(k);
      end
    end else begin
      out_valid_r <= 1'b0;
      if (coef_we && (state_r == IDLE) && addr_ok_s) h_r[coef_addr] <= coef_data;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            x_r[0] <= in_data;
            for (int k = 1; k < TAPS; k++) x_r[k] <= x_r[k-1];
            acc_r   <= '0;
            idx_r   <= '0;
            state_r <= MAC;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + AW'(1);
          if (idx_r == AW'(TAPS - 1)) state_r <= DONE;
        end
        DONE: begin
          out_data_r  <= clamp(acc_r);
          out_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule
